// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data alignment/extension, writeback result mux
// and retired-instruction counter for the RV32I pipeline.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [2:0]       WriteBackM,
  input  logic [2:0]       funct3M,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  ImmExtM,
  input  logic [XLEN-1:0]  PCTargetM,
  input  logic [4:0]       RdM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ResultW,
  output logic             ValidW,
  output logic [CNT_W-1:0] InstretW
);

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_LOAD = 3'b001;
  localparam logic [2:0] WB_PC4  = 3'b010;
  localparam logic [2:0] WB_IMM  = 3'b011;
  localparam logic [2:0] WB_PCT  = 3'b100;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic             valid_q,    valid_d;
  logic             regwrite_q, regwrite_d;
  logic [2:0]       wb_sel_q,   wb_sel_d;
  logic [2:0]       funct3_q,   funct3_d;
  logic [XLEN-1:0]  alu_q,      alu_d;
  logic [XLEN-1:0]  rdata_q,    rdata_d;
  logic [1:0]       offset_q,   offset_d;
  logic [XLEN-1:0]  pcplus4_q,  pcplus4_d;
  logic [XLEN-1:0]  imm_q,      imm_d;
  logic [XLEN-1:0]  pctarget_q, pctarget_d;
  logic [4:0]       rd_q,       rd_d;
  logic [CNT_W-1:0] instret_q,  instret_d;

  logic load_en;

  assign load_en = !FlushW && !StallW;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wb_sel_d   = wb_sel_q;
    funct3_d   = funct3_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    offset_d   = offset_q;
    pcplus4_d  = pcplus4_q;
    imm_d      = imm_q;
    pctarget_d = pctarget_q;
    rd_d       = rd_q;
    instret_d  = instret_q;
    if (FlushW) begin
      // Bubble: only the qualifying bits matter, the payload is left as-is.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM;
      wb_sel_d   = WriteBackM;
      funct3_d   = funct3M;
      alu_d      = ALUResultM;
      rdata_d    = ReadDataM;
      offset_d   = ALUResultM[1:0];
      pcplus4_d  = PCPlus4M;
      imm_d      = ImmExtM;
      pctarget_d = PCTargetM;
      rd_d       = RdM;
    end
    if (load_en && ValidM) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wb_sel_q   <= 3'b000;
      funct3_q   <= 3'b000;
      alu_q      <= '0;
      rdata_q    <= '0;
      offset_q   <= 2'b00;
      pcplus4_q  <= '0;
      imm_q      <= '0;
      pctarget_q <= '0;
      rd_q       <= 5'd0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wb_sel_q   <= wb_sel_d;
      funct3_q   <= funct3_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      offset_q   <= offset_d;
      pcplus4_q  <= pcplus4_d;
      imm_q      <= imm_d;
      pctarget_q <= pctarget_d;
      rd_q       <= rd_d;
      instret_q  <= instret_d;
    end
  end

  // Byte and halfword lanes of the raw memory word.
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = rdata_q[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = rdata_q[16*gi +: 16];
    end
  endgenerate

  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_data;

  assign sel_byte = byte_lane[offset_q];
  // Halfword lane uses offset[1] only; misaligned halves are not trapped here.
  assign sel_half = half_lane[offset_q[1]];

  always_comb begin
    load_data = rdata_q;
    case (funct3_q)
      F3_LB:   load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    ResultW = alu_q;
    case (wb_sel_q)
      WB_ALU:  ResultW = alu_q;
      WB_LOAD: ResultW = load_data;
      WB_PC4:  ResultW = pcplus4_q;
      WB_IMM:  ResultW = imm_q;
      WB_PCT:  ResultW = pctarget_q;
      default: ResultW = alu_q;
    endcase
  end

  // x0 is never written, but ResultW stays valid for forwarding.
  assign RegWriteW = regwrite_q && valid_q && (rd_q != 5'd0);
  assign RdW       = rd_q;
  assign ValidW    = valid_q;
  assign InstretW  = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage; a narrow-counter instance covers counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, StallW, FlushW;
  logic [2:0]  WriteBackM, funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM, PCTargetM;
  logic [4:0]  RdM;

  logic        RegWriteW, ValidW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [63:0] InstretW;

  logic        RegWriteW_n, ValidW_n;
  logic [4:0]  RdW_n;
  logic [31:0] ResultW_n;
  logic [2:0]  InstretW_n;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .WriteBackM(WriteBackM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .PCTargetM(PCTargetM), .RdM(RdM), .StallW(StallW), .FlushW(FlushW),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ValidW(ValidW),
    .InstretW(InstretW)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(3)) dut_n (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .WriteBackM(WriteBackM), .funct3M(funct3M), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .PCTargetM(PCTargetM), .RdM(RdM), .StallW(StallW), .FlushW(FlushW),
    .RegWriteW(RegWriteW_n), .RdW(RdW_n), .ResultW(ResultW_n), .ValidW(ValidW_n),
    .InstretW(InstretW_n)
  );

  typedef struct {
    logic        regwrite;
    logic [2:0]  wb;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_we;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_cnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive one M-stage instruction, clock it, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic rw, input logic [2:0] wb, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [4:0] rd,
                      input logic stall, input logic flush);
    ValidM = v; RegWriteM = rw; WriteBackM = wb; funct3M = f3;
    ALUResultM = alu; RdM = rd; StallW = stall; FlushW = flush;
    @(posedge clk);
    if (v && !stall && !flush) exp_cnt = exp_cnt + 64'd1;
    #1;
  endtask

  function automatic vec_t mk(input logic rw, input logic [2:0] wb, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [4:0] rd,
                              input logic [31:0] res, input logic we);
    vec_t t;
    t.regwrite = rw; t.wb = wb; t.f3 = f3; t.alu = alu; t.rd = rd;
    t.exp_res = res; t.exp_we = we;
    return t;
  endfunction

  initial begin
    vecs[0]  = mk(1, 3'b001, 3'b000, 32'h1000, 5'd1, 32'h00000001, 1);
    vecs[1]  = mk(1, 3'b001, 3'b000, 32'h1001, 5'd1, 32'h0000007F, 1);
    vecs[2]  = mk(1, 3'b001, 3'b000, 32'h1002, 5'd1, 32'hFFFFFFFF, 1);
    vecs[3]  = mk(1, 3'b001, 3'b100, 32'h1003, 5'd1, 32'h00000080, 1);
    vecs[4]  = mk(1, 3'b001, 3'b001, 32'h1000, 5'd2, 32'h00007F01, 1);
    vecs[5]  = mk(1, 3'b001, 3'b001, 32'h1002, 5'd2, 32'hFFFF80FF, 1);
    vecs[6]  = mk(1, 3'b001, 3'b101, 32'h1003, 5'd2, 32'h000080FF, 1);
    vecs[7]  = mk(1, 3'b001, 3'b010, 32'h1001, 5'd4, 32'h80FF7F01, 1);
    vecs[8]  = mk(1, 3'b001, 3'b011, 32'h1002, 5'd4, 32'h80FF7F01, 1);
    vecs[9]  = mk(1, 3'b000, 3'b010, 32'h00000011, 5'd6, 32'h00000011, 1);
    vecs[10] = mk(1, 3'b010, 3'b010, 32'h00000011, 5'd6, 32'h00000104, 1);
    vecs[11] = mk(1, 3'b011, 3'b010, 32'h00000011, 5'd6, 32'h12345000, 1);
    vecs[12] = mk(1, 3'b100, 3'b010, 32'h00000011, 5'd6, 32'h00002000, 1);
    vecs[13] = mk(1, 3'b111, 3'b010, 32'h00000011, 5'd6, 32'h00000011, 1);
    vecs[14] = mk(1, 3'b000, 3'b010, 32'h0000DEAD, 5'd0, 32'h0000DEAD, 0);
    vecs[15] = mk(1, 3'b000, 3'b010, 32'h0000DEAD, 5'd5, 32'h0000DEAD, 1);
    vecs[16] = mk(0, 3'b000, 3'b010, 32'h0000BEEF, 5'd5, 32'h0000BEEF, 0);

    ReadDataM = 32'h80FF7F01; PCPlus4M = 32'h104; ImmExtM = 32'h12345000; PCTargetM = 32'h2000;
    ValidM = 0; RegWriteM = 0; WriteBackM = 0; funct3M = 0; ALUResultM = 0; RdM = 0;
    StallW = 0; FlushW = 0;
    reset = 1'b1;
    #1;
    chk("rst_we", {63'd0, RegWriteW}, 64'd0);
    chk("rst_res", {32'd0, ResultW}, 64'd0);
    chk("rst_valid", {63'd0, ValidW}, 64'd0);
    chk("rst_cnt", InstretW, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load a writing instruction, then assert reset mid-cycle.
    step(1, 1, 3'b000, 3'b010, 32'h55, 5'd7, 0, 0);
    chk("pre_rst_we", {63'd0, RegWriteW}, 64'd1);
    chk("pre_rst_res", {32'd0, ResultW}, 64'h55);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", {63'd0, RegWriteW}, 64'd0);
    chk("async_rst_res", {32'd0, ResultW}, 64'd0);
    chk("async_rst_valid", {63'd0, ValidW}, 64'd0);
    chk("async_rst_cnt", InstretW, 64'd0);
    exp_cnt = 64'd0;
    #1 reset = 1'b0;

    // Stall / flush sequence.
    step(1, 1, 3'b000, 3'b010, 32'h0000000A, 5'd3, 0, 0);
    chk("A_rd", {59'd0, RdW}, 64'd3);
    chk("A_res", {32'd0, ResultW}, 64'hA);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3'b000, 3'b010, 32'h0000000B, 5'd9, 1, 0);
      chk("stall_rd", {59'd0, RdW}, 64'd3);
      chk("stall_res", {32'd0, ResultW}, 64'hA);
      chk("stall_we", {63'd0, RegWriteW}, 64'd1);
      chk("stall_cnt", InstretW, 64'd1);
    end
    step(1, 1, 3'b000, 3'b010, 32'h0000000B, 5'd9, 1, 1);
    chk("flush_valid", {63'd0, ValidW}, 64'd0);
    chk("flush_we", {63'd0, RegWriteW}, 64'd0);
    chk("flush_cnt", InstretW, 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, vecs[i].regwrite, vecs[i].wb, vecs[i].f3, vecs[i].alu, vecs[i].rd, 0, 0);
      n_vec++;
      if (ResultW !== vecs[i].exp_res || RegWriteW !== vecs[i].exp_we ||
          RdW !== vecs[i].rd || ValidW !== 1'b1 || InstretW !== exp_cnt) begin
        n_err++;
        $display("FAIL vec%0d: res=%h we=%b rd=%0d valid=%b cnt=%0d, required res=%h we=%b rd=%0d valid=1 cnt=%0d",
                 i, ResultW, RegWriteW, RdW, ValidW, InstretW,
                 vecs[i].exp_res, vecs[i].exp_we, vecs[i].rd, exp_cnt);
      end
    end

    // Counter wrap on the 3-bit instance; the 64-bit one keeps counting.
    begin
      int k;
      k = (7 - int'(exp_cnt[2:0])) & 7;
      for (int i = 0; i < k; i++) step(1, 0, 3'b000, 3'b010, 32'h0, 5'd0, 0, 0);
    end
    chk("wrap_pre", {61'd0, InstretW_n}, 64'd7);
    step(1, 0, 3'b000, 3'b010, 32'h0, 5'd0, 0, 0);
    chk("wrap_zero", {61'd0, InstretW_n}, 64'd0);
    chk("big_cnt", InstretW, exp_cnt);
    step(0, 0, 3'b000, 3'b010, 32'h0, 5'd0, 0, 0);
    chk("invalid_hold_n", {61'd0, InstretW_n}, 64'd0);
    chk("invalid_hold", InstretW, exp_cnt);
    chk("invalid_valid", {63'd0, ValidW}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback end of the RV32I pipeline: MEM/WB pipeline register, load-data alignment/extension and the writeback result mux.
- Drives the register-file write port of the decode stage: write enable, write address, write data.
- Also carries the WB-stage valid bit and a 64-bit retired-instruction counter.
- Sits between the MEM stage/data memory and the decode-stage register file; ResultW is also the WB forwarding source for EX.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ValidM  input  1  MEM stage holds a real instruction
- RegWriteM  input  1  instruction writes rd
- WriteBackM  input  3  result select: 000 ALU, 001 load, 010 PC+4, 011 ImmExt (LUI), 100 PC target (AUIPC); 101-111 treated as ALU
- funct3M  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- ALUResultM  input  XLEN  ALU result / load address
- ReadDataM  input  XLEN  raw aligned word from data memory
- PCPlus4M  input  XLEN  link value
- ImmExtM  input  XLEN  extended immediate
- PCTargetM  input  XLEN  PC+imm
- RdM  input  5  destination register
- StallW  input  1  hold WB register
- FlushW  input  1  insert bubble into WB
- RegWriteW  output  1  register-file write enable (we3)
- RdW  output  5  register-file write address
- ResultW  output  XLEN  register-file write data (a3)
- ValidW  output  1  WB holds a real instruction
- InstretW  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, active-high): all WB register fields 0, InstretW=0. Outputs then: RegWriteW=0, RdW=0, ResultW=0 (WB select 000, ALU field 0), ValidW=0.
- WB register update on rising clk; priority order: reset > FlushW > StallW > load.
  - FlushW=1: ValidW_reg=0, RegWrite_reg=0; other fields don't-care. FlushW wins over StallW.
  - StallW=1 (no flush): every field holds.
  - Otherwise: capture all M inputs. ReadDataM is captured raw, together with ALUResultM[1:0] as the byte offset.
- Latency: one cycle. Values presented in cycle N appear on the outputs in cycle N+1.
- Load extraction is combinational from the registered fields:
  - Byte: lane = offset[1:0]; LB sign-extends, LBU zero-extends.
  - Half: lane = offset[1] (offset[0] ignored, no misalign trap); LH sign-extends, LHU zero-extends.
  - LW/other: whole word, offset ignored.
- ResultW is a combinational mux by the registered WB select over ALU, extracted load, PC+4, ImmExt and PCTarget.
- RegWriteW = RegWrite_reg & ValidW_reg & (RdW != 0). Writes to x0 are never issued; ResultW is still driven.
- RdW = registered RdM, unmasked.
- InstretW increments by 1 on each clock edge where the register loads (no reset/flush/stall) and ValidM=1.
  - A stalled instruction is counted once.
  - A flush counts nothing.
  - Wraps from all-ones to 0.
- Reset mid-stall or mid-flush: reset wins; outputs return to reset values immediately (asynchronous).
- The module adds no combinational path from M inputs to W outputs.

Test Plan:
- Reset: assert reset mid-cycle with RegWriteM=1 loaded -> RegWriteW=0, ResultW=0, ValidW=0, InstretW=0 before the next edge.
- Load extension: ReadDataM=0x80FF7F01, WriteBackM=001, sweep each ALUResultM[1:0] and funct3M. Required results, one cycle later:
  - LB off0 -> 0x00000001; LB off1 -> 0x0000007F; LB off2 -> 0xFFFFFFFF; LBU off3 -> 0x00000080.
  - LH off0 -> 0x00007F01; LH off2 -> 0xFFFF80FF; LHU off3 -> 0x000080FF.
  - LW off1 -> 0x80FF7F01.
- Mux select: ALU=0x11, PCPlus4=0x104, Imm=0x12345000, PCTarget=0x2000. WriteBackM=000/010/011/100/111 -> ResultW=0x11/0x104/0x12345000/0x2000/0x11.
- x0 suppression: RegWriteM=1, RdM=0, ALU=0xDEAD -> RegWriteW=0, ResultW=0xDEAD. With RdM=5 -> RegWriteW=1, RdW=5.
- Stall/flush: load instr A (Rd=3); next cycle StallW=1 with B at M for 3 cycles -> outputs hold A and InstretW=1. Then FlushW=1 and StallW=1 together -> ValidW=0, RegWriteW=0, InstretW stays 1.
- Counter wrap: preset via 2^64-1 valid loads (or force) -> next valid load gives InstretW=0; ValidM=0 loads leave the count unchanged.
